mem_stream_mux: RTL and testbench

Parametrised successor of the fixed 12-port memory mux. It routes the memory port chosen by the priority encoder into a framed, flow-controlled output stream, one frame per bunch crossing (BX): a header word, then data words, then a trailer word carrying the data-word count. It sits between the priority encoder / memory read ports and the link serialiser. It adds valid/ready backpressure, a BX frame state machine and bad-select detection to the plain registered mux.

---
 rtl/mem_stream_pkg.sv | 42 ++++
 rtl/stream_out_reg.sv | 51 +++++
 rtl/mem_stream_mux.sv | 181 ++++++++++++++++++
 tb/tb_mem_stream_mux.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stream_pkg.sv
// Shared definitions for the framed memory stream mux.
//   FLAG_*    : word-type codes carried in the top two bits of every output word
//   state_e   : BX frame state machine encoding
//   pack_word : assembles {flag, bx, sel, payload} for any parameter set
package mem_stream_pkg;

  localparam logic [1:0] FLAG_HDR  = 2'b01;
  localparam logic [1:0] FLAG_DATA = 2'b10;
  localparam logic [1:0] FLAG_TRL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StData,
    StTrailer
  } state_e;

  // Wide enough for any practical output word; callers slice the low OUT_W bits.
  localparam int unsigned WordMaxW = 256;
  typedef logic [WordMaxW-1:0] word_t;

  function automatic word_t field_mask(input int unsigned width);
    return (word_t'(1) << width) - word_t'(1);
  endfunction

  // Fields are masked to their widths so oversized inputs cannot bleed upward.
  function automatic word_t pack_word(input logic [1:0]  flag,
                                      input word_t       bx,
                                      input word_t       sel,
                                      input word_t       payload,
                                      input int unsigned bx_w,
                                      input int unsigned sel_w,
                                      input int unsigned data_w);
    word_t w;
    w = word_t'(flag);
    w = (w << bx_w) | (bx & field_mask(bx_w));
    w = (w << sel_w) | (sel & field_mask(sel_w));
    w = (w << data_w) | (payload & field_mask(data_w));
    return w;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Registered valid/ready output stage that holds its word under backpressure.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   in_valid_i     : upstream offers in_data_i this cycle
//   in_data_i      : word to load
//   in_ready_o     : register can load this cycle (empty or being drained)
//   out_valid_o    : registered word valid
//   out_data_o     : registered word, stable while out_valid_o & !out_ready_i
//   out_ready_i    : downstream accepts
module stream_out_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             valid_d, valid_q;
  logic [Width-1:0] data_d, data_q;

  assign in_ready_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/mem_stream_mux.sv
// Routes the selected memory port into a framed, flow-controlled stream: one
// header, the data words, and a trailer carrying the data-word count per BX.
//   clk, reset            : clock, asynchronous active-high reset
//   bx_start, bx_in       : new-BX pulse and its number
//   sel, sel_valid        : port selection; accepted on sel_valid & sel_ready
//   sel_ready             : high only in DATA while the output register can load
//   bx_done               : no more selections for the current BX
//   mem_dat               : flattened port data, port i at [i*DATA_W +: DATA_W]
//   out_data/valid/ready  : output stream {flag, bx, sel, payload}
//   err_bad_sel           : registered pulse, accepted sel >= N_PORTS
//   err_overrun           : registered pulse, pending BX overwritten
module mem_stream_mux
  import mem_stream_pkg::*;
#(
  parameter int unsigned N_PORTS = 12,
  parameter int unsigned DATA_W  = 45,
  parameter int unsigned BX_W    = 3,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned SEL_W  = $clog2(N_PORTS + 1),
  localparam int unsigned OUT_W  = 2 + BX_W + SEL_W + DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bx_start,
  input  logic [BX_W-1:0]           bx_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_valid,
  output logic                      sel_ready,
  input  logic                      bx_done,
  input  logic [N_PORTS*DATA_W-1:0] mem_dat,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err_bad_sel,
  output logic                      err_overrun
);

  // All-ones select marks header and trailer words.
  localparam logic [SEL_W-1:0] SelMarker = '1;

  state_e            state_d, state_q;
  logic [BX_W-1:0]   bx_d, bx_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              pend_vld_d, pend_vld_q;
  logic [BX_W-1:0]   pend_bx_d, pend_bx_q;
  logic              bad_sel_d, bad_sel_q;
  logic              overrun_d, overrun_q;

  logic              load_ok;
  logic              word_vld;
  word_t             word_full;
  logic [OUT_W-1:0]  word_data;
  logic [DATA_W-1:0] sel_dat;
  logic              sel_ok;

  assign sel_ok    = sel < SEL_W'(N_PORTS);
  assign sel_ready = (state_q == StData) && load_ok;
  assign word_data = word_full[OUT_W-1:0];

  always_comb begin
    sel_dat = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_dat = mem_dat[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bx_d       = bx_q;
    cnt_d      = cnt_q;
    pend_vld_d = pend_vld_q;
    pend_bx_d  = pend_bx_q;
    bad_sel_d  = 1'b0;
    overrun_d  = 1'b0;
    word_vld   = 1'b0;
    word_full  = '0;

    // Outside IDLE a new BX waits in the one-deep slot; TRAILER may override below.
    if (bx_start && (state_q != StIdle)) begin
      pend_vld_d = 1'b1;
      pend_bx_d  = bx_in;
      overrun_d  = pend_vld_q;
    end

    unique case (state_q)
      StIdle: begin
        if (bx_start) begin
          bx_d    = bx_in;
          state_d = StHeader;
        end
      end
      StHeader: begin
        word_vld  = 1'b1;
        word_full = pack_word(FLAG_HDR, word_t'(bx_q), word_t'(SelMarker), '0,
                              BX_W, SEL_W, DATA_W);
        if (load_ok) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (sel_valid && load_ok) begin
          if (sel_ok) begin
            word_vld  = 1'b1;
            word_full = pack_word(FLAG_DATA, word_t'(bx_q), word_t'(sel), word_t'(sel_dat),
                                  BX_W, SEL_W, DATA_W);
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            bad_sel_d = 1'b1;
          end
        end
        if (bx_done) begin
          state_d = StTrailer;
        end
      end
      StTrailer: begin
        word_vld  = 1'b1;
        word_full = pack_word(FLAG_TRL, word_t'(bx_q), word_t'(SelMarker), word_t'(cnt_q),
                              BX_W, SEL_W, DATA_W);
        if (load_ok) begin
          if (pend_vld_q) begin
            // Slot drains into the next frame; a same-cycle bx_start refills it.
            state_d    = StHeader;
            bx_d       = pend_bx_q;
            pend_vld_d = bx_start;
            overrun_d  = 1'b0;
          end else if (bx_start) begin
            state_d    = StHeader;
            bx_d       = bx_in;
            pend_vld_d = 1'b0;
            overrun_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bx_q       <= '0;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_bx_q  <= '0;
      bad_sel_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bx_q       <= bx_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_bx_q  <= pend_bx_d;
      bad_sel_q  <= bad_sel_d;
      overrun_q  <= overrun_d;
    end
  end

  stream_out_reg #(
    .Width(OUT_W)
  ) u_out_reg (
    .clk_i      (clk),
    .rst_i      (reset),
    .in_valid_i (word_vld),
    .in_data_i  (word_data),
    .in_ready_o (load_ok),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready)
  );

  assign err_bad_sel = bad_sel_q;
  assign err_overrun = overrun_q;

endmodule

// File: tb/tb_mem_stream_mux.sv
module tb_mem_stream_mux;

  localparam int NP = 12;
  localparam int DW = 45;
  localparam int BW = 3;
  localparam int CW = 8;
  localparam int SW = 4;
  localparam int OW = 54;

  logic             clk = 1'b0;
  logic             reset;
  logic             bx_start;
  logic [BW-1:0]    bx_in;
  logic [SW-1:0]    sel;
  logic             sel_valid;
  logic             sel_ready;
  logic             bx_done;
  logic [NP*DW-1:0] mem_dat;
  logic [OW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             err_bad_sel;
  logic             err_overrun;

  mem_stream_mux #(
    .N_PORTS(NP),
    .DATA_W (DW),
    .BX_W   (BW),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bx_start   (bx_start),
    .bx_in      (bx_in),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .bx_done    (bx_done),
    .mem_dat    (mem_dat),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_bad_sel(err_bad_sel),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            n_ovr = 0;
  int            n_bad = 0;
  int            cnt = 0;
  int            rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random
  logic [BW-1:0] cur_bx = '0;
  logic          bad_exp = 1'b0;
  logic          prev_stall = 1'b0;
  logic          last_acc = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic [OW-1:0] exp_w;
  logic [OW-1:0] exp_q[$];

  function automatic logic [OW-1:0] mk(logic [1:0] f, logic [BW-1:0] b, logic [SW-1:0] s,
                                      logic [DW-1:0] p);
    return {f, b, s, p};
  endfunction

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: check/model at the negedge, then advance and drive new inputs.
  task automatic step();
    int s;
    @(negedge clk);
    chk("err_bad_sel", OW'(err_bad_sel), OW'(bad_exp));
    if (err_bad_sel === 1'b1) n_bad++;
    if (err_overrun === 1'b1) n_ovr++;
    if (prev_stall) begin
      chk("hold_valid", OW'(out_valid), OW'(1));
      chk("hold_data", out_data, prev_data);
    end
    if (out_valid === 1'b1 && out_ready === 1'b0) chk("stall_sel_ready", OW'(sel_ready), '0);
    last_acc = sel_valid && (sel_ready === 1'b1);
    bad_exp  = 1'b0;
    if (last_acc) begin
      s = int'(sel);
      if (s < NP) begin
        exp_q.push_back(mk(2'b10, cur_bx, sel, mem_dat[s*DW +: DW]));
        cnt++;
      end else begin
        bad_exp = 1'b1;
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", out_data, '0);
      end else begin
        exp_w = exp_q.pop_front();
        chk("out_word", out_data, exp_w);
      end
    end
    prev_stall = (out_valid === 1'b1) && !out_ready;
    prev_data  = out_data;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) mem_dat[p*DW +: DW] = DW'({$urandom(), $urandom()});
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic begin_frame(input logic [BW-1:0] b);
    cur_bx = b;
    cnt    = 0;
    exp_q.push_back(mk(2'b01, b, 4'hF, '0));
  endtask

  task automatic start_bx(input logic [BW-1:0] b);
    bx_start = 1'b1;
    bx_in    = b;
    step();
    bx_start = 1'b0;
  endtask

  task automatic send_sel(input logic [SW-1:0] s);
    sel       = s;
    sel_valid = 1'b1;
    last_acc  = 1'b0;
    for (int k = 0; k < 100 && !last_acc; k++) step();
    if (!last_acc) chk("sel_accept_timeout", OW'(last_acc), OW'(1));
    sel_valid = 1'b0;
  endtask

  task automatic end_bx();
    bx_done = 1'b1;
    step();
    bx_done = 1'b0;
    exp_q.push_back(mk(2'b11, cur_bx, 4'hF, DW'(cnt > 255 ? 255 : cnt)));
  endtask

  task automatic drain();
    rdy_mode  = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) step();
    chk("drain_left", OW'(exp_q.size()), '0);
    repeat (3) step();
    chk("idle_valid", OW'(out_valid), '0);
  endtask

  initial begin
    reset     = 1'b1;
    bx_start  = 1'b0;
    bx_in     = '0;
    sel       = '0;
    sel_valid = 1'b0;
    bx_done   = 1'b0;
    mem_dat   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", OW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_sel_ready", OW'(sel_ready), '0);
    chk("rst_err_bad_sel", OW'(err_bad_sel), '0);
    chk("rst_err_overrun", OW'(err_overrun), '0);
    reset = 1'b0;
    step();

    // Basic frame: bx 5, ports 0, 3, 11.
    begin_frame(3'd5);
    start_bx(3'd5);
    send_sel(4'd0);
    send_sel(4'd3);
    send_sel(4'd11);
    end_bx();
    drain();

    // Backpressure mid-DATA.
    begin_frame(3'd6);
    start_bx(3'd6);
    send_sel(4'd1);
    send_sel(4'd2);
    rdy_mode  = 1;
    out_ready = 1'b0;
    sel       = 4'd4;
    sel_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_no_accept", OW'(last_acc), '0);
    end
    rdy_mode  = 0;
    out_ready = 1'b1;
    send_sel(4'd4);
    end_bx();
    drain();

    // Bad selects are dropped and not counted.
    n_bad = 0;
    begin_frame(3'd7);
    start_bx(3'd7);
    send_sel(4'd2);
    send_sel(4'd12);
    send_sel(4'd6);
    send_sel(4'd14);
    end_bx();
    drain();
    chk("bad_sel_pulses", OW'(n_bad), OW'(2));

    // Two BX starts during DATA of bx 1: second overwrites the first.
    n_ovr = 0;
    begin_frame(3'd1);
    start_bx(3'd1);
    send_sel(4'd0);
    send_sel(4'd5);
    start_bx(3'd2);
    send_sel(4'd7);
    start_bx(3'd3);
    send_sel(4'd9);
    end_bx();
    begin_frame(3'd3);
    send_sel(4'd10);
    end_bx();
    drain();
    chk("overrun_pulses", OW'(n_ovr), OW'(1));

    // Count saturation.
    begin_frame(3'd4);
    start_bx(3'd4);
    for (int i = 0; i < 300; i++) send_sel(SW'($urandom_range(0, NP - 1)));
    end_bx();
    drain();

    // Random frames, random selects (some bad) and random ready, back to back.
    n_ovr    = 0;
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      logic [BW-1:0] b;
      int            n;
      b = BW'($urandom_range(0, 7));
      n = int'($urandom_range(1, 12));
      begin_frame(b);
      start_bx(b);
      for (int i = 0; i < n; i++) send_sel(SW'($urandom_range(0, 15)));
      end_bx();
    end
    drain();
    chk("random_no_overrun", OW'(n_ovr), '0);

    // Reset mid-frame aborts; next BX gets a fresh header.
    begin_frame(3'd2);
    start_bx(3'd2);
    send_sel(4'd3);
    send_sel(4'd8);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", OW'(out_valid), '0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_sel_ready", OW'(sel_ready), '0);
    chk("midrst_err_bad_sel", OW'(err_bad_sel), '0);
    chk("midrst_err_overrun", OW'(err_overrun), '0);
    exp_q.delete();
    bad_exp    = 1'b0;
    prev_stall = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("post_rst_idle", OW'(out_valid), '0);
    begin_frame(3'd6);
    start_bx(3'd6);
    send_sel(4'd11);
    end_bx();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
